// File: rtl/uart_pkg.sv
// Shared UART definitions: baud div codes, the baud_sequencer state encoding,
// the default oversample ratio and a counter-width helper.
package uart_pkg;

  typedef logic [1:0] div_t;

  localparam div_t DIV_115200 = 2'b00;
  localparam div_t DIV_57600  = 2'b01;
  localparam div_t DIV_38400  = 2'b10;
  localparam div_t DIV_19200  = 2'b11;

  // baud_sequencer FSM encoding
  localparam logic [2:0] StRun     = 3'd0;
  localparam logic [2:0] StPending = 3'd1;
  localparam logic [2:0] StApply   = 3'd2;
  localparam logic [2:0] StSettle  = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam int unsigned DEFAULT_OVERSAMPLE = 10;

  // Width of a counter that must hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_sequencer_if.sv
// Baud-change request handshake between the command decoder and baud_sequencer.
//   req_valid : request present (held by the requester until accepted)
//   req_div   : requested div code
//   req_ready : request accepted in a cycle where req_valid & req_ready
// master = command decoder, slave = baud_sequencer.
interface baud_sequencer_if;
  import uart_pkg::*;

  logic req_valid;
  div_t req_div;
  logic req_ready;

  modport master (output req_valid, output req_div, input req_ready);
  modport slave  (input req_valid, input req_div, output req_ready);

endinterface

// File: rtl/baud_tick_gen.sv
// Turns the prescaler's scaled strobe into the receiver oversample tick and the
// transmitter bit tick (one per OVERSAMPLE gated strobes).
//   clock, reset : system clock, asynchronous active-high reset
//   i_scaled     : one-cycle strobe from the prescaler
//   i_enable     : tick gate; strobes seen while low are dropped entirely
//   i_clear      : zero the oversample counter
//   o_rx_tick    : gated strobe delayed one cycle
//   o_tx_tick    : subset of o_rx_tick, on every OVERSAMPLE-th gated strobe
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clock,
  input  logic reset,
  input  logic i_scaled,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_rx_tick,
  output logic o_tx_tick
);

  localparam int unsigned CntW = cnt_width(OVERSAMPLE);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);

  logic [CntW-1:0] r_cnt;
  logic            r_rx_tick;
  logic            r_tx_tick;
  logic            w_strobe;
  logic            w_wrap;

  assign w_strobe = i_scaled & i_enable;
  assign w_wrap   = (r_cnt == CntLast);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_rx_tick <= 1'b0;
      r_tx_tick <= 1'b0;
    end else begin
      r_rx_tick <= w_strobe;
      // tx_tick follows the pre-clear count, so a realign on a strobe cycle
      // still honours a bit boundary that was already due.
      r_tx_tick <= w_strobe & w_wrap;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (w_strobe) begin
        r_cnt <= w_wrap ? '0 : r_cnt + CntW'(1);
      end
    end
  end

  assign o_rx_tick = r_rx_tick;
  assign o_tx_tick = r_tx_tick;

endmodule

// File: rtl/baud_sequencer.sv
// Controller for the shared UART prescaler. Owns div select and phase clear,
// applies host baud changes only once tx and rx are both idle, and derives the
// rx oversample / tx bit ticks from the prescaler strobe.
//   clock, reset    : system clock, asynchronous active-high reset
//   i_scaled        : one-cycle strobe from the prescaler
//   req_if          : baud-change request handshake (slave side)
//   i_tx_idle       : transmitter has no frame in progress
//   i_rx_idle       : receiver has no frame in progress
//   o_div_out       : div select to the prescaler
//   o_presc_clear   : one-cycle pulse, ORed with reset at the prescaler
//   o_rx_tick       : receiver oversample tick
//   o_tx_tick       : transmitter bit tick
//   o_change_done   : one-cycle pulse once the new div is in effect
//   o_forced        : last change was forced by timeout (0 unless enabled)
// Build option: define BAUD_SEQ_TIMEOUT_EN to force an apply after TIMEOUT
// cycles in PENDING; otherwise PENDING waits for idle indefinitely.
module baud_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE    = DEFAULT_OVERSAMPLE,
  parameter div_t        DEFAULT_DIV   = DIV_115200,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_scaled,
  baud_sequencer_if.slave        req_if,
  input  logic                   i_tx_idle,
  input  logic                   i_rx_idle,
  output logic [1:0]             o_div_out,
  output logic                   o_presc_clear,
  output logic                   o_rx_tick,
  output logic                   o_tx_tick,
  output logic                   o_change_done,
  output logic                   o_forced
);

  localparam logic [2:0] SettleLast = 3'(SETTLE_CYCLES - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_d;
  div_t       r_div;
  div_t       r_pend_div;
  logic       r_presc_clear;
  logic       r_change_done;
  logic       r_req_ready;
  logic [2:0] r_settle_cnt;
  logic       w_both_idle;
  logic       w_handshake;
  logic       w_tick_enable;
  logic       w_cnt_clear;
  logic       w_timeout;

  assign w_both_idle = i_tx_idle & i_rx_idle;
  assign w_handshake = req_if.req_valid & r_req_ready;

`ifdef BAUD_SEQ_TIMEOUT_EN
  localparam int unsigned ToW = cnt_width(TIMEOUT);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

  logic [ToW-1:0] r_to_cnt;
  logic           r_forced;

  assign w_timeout = (r_state == StPending) && (r_to_cnt == ToLast);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_forced <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == StPending) ? r_to_cnt + ToW'(1) : '0;
      if (w_handshake) begin
        r_forced <= 1'b0;
      end else if (w_timeout && !w_both_idle) begin
        r_forced <= 1'b1;
      end
    end
  end

  assign o_forced = r_forced;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
  assign o_forced         = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StRun: begin
        if (w_handshake) begin
          w_state_d = (req_if.req_div == r_div) ? StDone : StPending;
        end
      end
      StPending: begin
        if (w_both_idle || w_timeout) begin
          w_state_d = StApply;
        end
      end
      StApply:  w_state_d = StSettle;
      StSettle: begin
        if (r_settle_cnt == SettleLast) begin
          w_state_d = StDone;
        end
      end
      StDone:   w_state_d = StRun;
      default:  w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= StRun;
      r_div         <= DEFAULT_DIV;
      r_pend_div    <= DEFAULT_DIV;
      r_presc_clear <= 1'b0;
      r_change_done <= 1'b0;
      r_req_ready   <= 1'b1;
      r_settle_cnt  <= '0;
    end else begin
      r_state <= w_state_d;
      // Registered from next state so ready is exactly "state is RUN".
      r_req_ready <= (w_state_d == StRun);
      if (w_handshake) begin
        r_pend_div <= req_if.req_div;
      end
      if (r_state == StApply) begin
        r_div <= r_pend_div;
      end
      r_presc_clear <= (r_state == StApply);
      r_change_done <= (r_state == StDone);
      r_settle_cnt  <= (r_state == StSettle) ? r_settle_cnt + 3'd1 : 3'd0;
    end
  end

  assign w_tick_enable = (r_state != StApply) && (r_state != StSettle);
  // Idle in RUN marks a frame boundary, so the bit phase restarts there too.
  assign w_cnt_clear   = (r_state == StApply) || ((r_state == StRun) && w_both_idle);

  baud_tick_gen #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick_gen (
    .clock     (clock),
    .reset     (reset),
    .i_scaled  (i_scaled),
    .i_enable  (w_tick_enable),
    .i_clear   (w_cnt_clear),
    .o_rx_tick (o_rx_tick),
    .o_tx_tick (o_tx_tick)
  );

  assign req_if.req_ready = r_req_ready;
  assign o_div_out        = r_div;
  assign o_presc_clear    = r_presc_clear;
  assign o_change_done    = r_change_done;

endmodule

// File: tb/tb_baud_sequencer.sv
// Bench for baud_sequencer: directed scenarios plus a random phase, every cycle
// compared against a timeline-based reference model of the baud-change flow.
module tb_baud_sequencer;
  import uart_pkg::*;

  localparam int OS  = 10;
  localparam int S   = 2;
  localparam logic [1:0] DEF = 2'b00;
`ifdef BAUD_SEQ_TIMEOUT_EN
  localparam int TO  = 16;
`else
  localparam int TO  = 4096;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       scaled;
  logic       tx_idle;
  logic       rx_idle;
  logic [1:0] div_out;
  logic       presc_clear;
  logic       rx_tick;
  logic       tx_tick;
  logic       change_done;
  logic       forced;

  baud_sequencer_if req_if ();

  baud_sequencer #(
    .OVERSAMPLE    (OS),
    .DEFAULT_DIV   (DEF),
    .SETTLE_CYCLES (S),
    .TIMEOUT       (TO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_scaled      (scaled),
    .req_if        (req_if),
    .i_tx_idle     (tx_idle),
    .i_rx_idle     (rx_idle),
    .o_div_out     (div_out),
    .o_presc_clear (presc_clear),
    .o_rx_tick     (rx_tick),
    .o_tx_tick     (tx_tick),
    .o_change_done (change_done),
    .o_forced      (forced)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a change is either waiting for idle, or running along a
  // fixed timeline (pos 0 = apply cycle, 1..S settle, S+1 done).
  logic [1:0] m_div, m_pend;
  bit         m_ready, m_pending, m_same, m_forced;
  int         m_pos, m_strobes, m_tcnt;
  bit         exp_rx, exp_tx, exp_clear, exp_done;

  function automatic void model_reset();
    m_div = DEF; m_pend = DEF; m_ready = 1; m_pending = 0; m_same = 0; m_forced = 0;
    m_pos = -1; m_strobes = 0; m_tcnt = 0;
    exp_rx = 0; exp_tx = 0; exp_clear = 0; exp_done = 0;
  endfunction

  function automatic void model_step(bit sc, bit vld, logic [1:0] dv, bit txi, bit rxi);
    bit in_run, idle, en;
    in_run = m_ready;
    idle   = txi & rxi;
    en     = !(m_pos >= 0 && m_pos <= S);
    exp_rx = sc & en;
    exp_tx = sc & en & (((m_strobes + 1) % OS) == 0);
    if (m_pos == 0 || (in_run && idle)) m_strobes = 0;
    else if (sc && en) m_strobes++;
    exp_clear = (m_pos == 0);
    if (m_pos == 0) m_div = m_pend;
    exp_done = (m_pos == S + 1) || m_same;
    if (in_run) begin
      if (vld) begin
        m_pend = dv; m_forced = 0; m_ready = 0;
        if (dv == m_div) m_same = 1;
        else begin m_pending = 1; m_tcnt = 0; end
      end
    end else if (m_same) begin
      m_same = 0; m_ready = 1;
    end else if (m_pending) begin
      if (idle) begin
        m_pending = 0; m_pos = 0;
`ifdef BAUD_SEQ_TIMEOUT_EN
      end else if (m_tcnt == TO - 1) begin
        m_pending = 0; m_pos = 0; m_forced = 1;
`endif
      end else begin
        m_tcnt++;
      end
    end else if (m_pos >= 0) begin
      if (m_pos == S + 1) begin m_pos = -1; m_ready = 1; end
      else m_pos++;
    end
  endfunction

  task automatic check_outputs();
    check_eq("rx_tick", rx_tick, exp_rx);
    check_eq("tx_tick", tx_tick, exp_tx);
    check_eq("presc_clear", presc_clear, exp_clear);
    check_eq("change_done", change_done, exp_done);
    check_eq("div_out", div_out, m_div);
    check_eq("req_ready", req_if.req_ready, m_ready);
    check_eq("forced", forced, m_forced);
  endtask

  // Called at a negedge: drive inputs, advance model, check at next negedge.
  task automatic cycle(input bit sc, input bit vld, input logic [1:0] dv,
                       input bit txi, input bit rxi);
    scaled = sc; req_if.req_valid = vld; req_if.req_div = dv;
    tx_idle = txi; rx_idle = rxi;
    model_step(sc, vld, dv, txi, rxi);
    @(negedge clock);
    cyc++;
    check_outputs();
  endtask

  task automatic apply_reset();
    scaled = 0; req_if.req_valid = 0; req_if.req_div = 0; tx_idle = 0; rx_idle = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int t_clr, t_done, n_clr, n_done, n_rx, n_tx;

    apply_reset();

    // 25 strobes at the default rate; tx on strobes 10 and 20
    n_rx = 0; n_tx = 0;
    for (int i = 1; i <= 25; i++) begin
      cycle(1, 0, 0, 0, 0);
      check_eq("rx_after_strobe", rx_tick, 1);
      check_eq("tx_on_strobe", tx_tick, (i % 10) == 0);
      n_rx += int'(rx_tick); n_tx += int'(tx_tick);
      cycle(0, 0, 0, 0, 0);
    end
    check_eq("rx_count", n_rx, 25);
    check_eq("tx_count", n_tx, 2);
    check_eq("div_default", div_out, 0);

    // Request 11 while busy: 50 cycles pending, then idle applies it
    cycle(0, 1, 2'b11, 0, 1);
    for (int i = 0; i < 50; i++) begin
      cycle((i % 3) == 0, 1, 2'b11, 0, 1);
      check_eq("pending_ready", req_if.req_ready, 0);
    end
    t_clr = -1; t_done = -1; n_clr = 0; n_done = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, 1, 1);
      if (presc_clear) begin n_clr++; t_clr = cyc; end
      if (change_done) begin n_done++; t_done = cyc; end
    end
    check_eq("clear_pulses", n_clr, 1);
    check_eq("done_pulses", n_done, 1);
    check_eq("done_delay", t_done - t_clr, 1 + S);
    check_eq("div_applied", div_out, 3);

    // Same div: done right after, no clear
    cycle(0, 1, 2'b11, 1, 1);
    cycle(0, 0, 0, 1, 1);
    check_eq("same_done", change_done, 1);
    check_eq("same_no_clear", presc_clear, 0);

    // Strobes in APPLY and SETTLE are dropped; counter restarts afterwards
    cycle(0, 1, 2'b00, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0);
    check_eq("rx_apply", rx_tick, 0);
    cycle(1, 0, 0, 0, 0);
    check_eq("rx_settle", rx_tick, 0);
    check_eq("tx_settle", tx_tick, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 0, 0, 0, 0);
      check_eq("tx_restart", tx_tick, i == 10);
      cycle(0, 0, 0, 0, 0);
    end

    // Reset during SETTLE of a change to 10
    cycle(0, 1, 2'b10, 1, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0);
    check_eq("settle_div", div_out, 2);
    apply_reset();
    check_eq("rst_div", div_out, 0);
    check_eq("rst_ready", req_if.req_ready, 1);
    cycle(0, 0, 0, 0, 0);

`ifdef BAUD_SEQ_TIMEOUT_EN
    cycle(0, 1, 2'b11, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
    check_eq("to_forced", forced, 1);
    check_eq("to_div", div_out, 3);
    cycle(0, 1, 2'b01, 0, 0);
    check_eq("to_forced_clr", forced, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 1);
`endif

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/baud_sequencer.md
Name: baud_sequencer

Overview:
- Controller for the shared UART prescaler. It owns the prescaler's div select and phase clear, and applies host baud-rate changes only when both transmitter and receiver are idle.
- Turns the prescaler's scaled strobe into two tick streams: an oversample tick for the receiver and a bit tick for the transmitter.
- Sits between the command decoder, the prescaler instance, and the UART tx/rx engines.

Parameters:
- OVERSAMPLE, 10: scaled strobes per transmitter bit; legal range 2..16.
- DEFAULT_DIV, 2'b00: div applied at reset (fastest rate).
- SETTLE_CYCLES, 2: clock cycles ticks stay suppressed after a clear; legal range 1..7.
- TIMEOUT, 4096: clock cycles allowed in PENDING before a forced apply (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- scaled  in  1  one-cycle strobe from the prescaler
- req_valid  in  1  baud-change request from the command decoder
- req_div  in  2  requested div code (00=115200, 01=57600, 10=38400, 11=19200)
- req_ready  out  1  request can be accepted this cycle
- tx_idle  in  1  transmitter has no frame in progress
- rx_idle  in  1  receiver has no frame in progress
- div_out  out  2  div select driven to the prescaler
- presc_clear  out  1  registered pulse, ORed with reset into the prescaler reset input
- rx_tick  out  1  receiver oversample tick
- tx_tick  out  1  transmitter bit tick
- change_done  out  1  one-cycle pulse when the new div is in effect
- forced  out  1  sticky flag: last change was forced (optional feature only)

Behaviour:
- Reset values: div_out=DEFAULT_DIV, presc_clear=0, rx_tick=0, tx_tick=0, change_done=0, forced=0. State is RUN; the oversample counter is 0.
- All outputs are registered.
- rx_tick = scaled delayed one cycle, gated by tick_enable.
- tx_tick: a counter increments on each gated scaled strobe. When it reaches OVERSAMPLE-1 it wraps to 0 and tx_tick pulses in the cycle rx_tick pulses for that strobe. tx_tick is therefore a subset of rx_tick.
- Counter width is clog2(OVERSAMPLE), minimum 1.
- tick_enable is 1 in RUN and PENDING, 0 in APPLY and SETTLE.
- FSM transitions:
  - RUN: req_ready=1. On a handshake (req_valid & req_ready), latch req_div into pend_div.
    - pend_div == div_out: go to DONE (no clear issued).
    - Otherwise: go to PENDING.
  - PENDING: req_ready=0; ticks continue at the old rate.
    - tx_idle & rx_idle sampled high in the same cycle: go to APPLY.
  - APPLY (1 cycle): div_out <= pend_div, presc_clear <= 1, oversample counter <= 0; go to SETTLE.
  - SETTLE: presc_clear returns to 0 on entry and stays 0. Remain SETTLE_CYCLES cycles, then go to DONE.
  - DONE (1 cycle): change_done=1; go to RUN. req_ready=0 in DONE.
- Boundaries:
  - Requests presented while req_ready=0 are ignored; the requester holds req_valid.
  - A scaled strobe arriving in the APPLY cycle or during SETTLE produces no tick.
  - Idle dropping in the same cycle the FSM enters APPLY still completes the change; the decision uses the registered sample.
  - Asynchronous reset mid-change discards pend_div, restores DEFAULT_DIV and returns to RUN. presc_clear is 0 after reset; the prescaler is held by the system reset itself.
  - The oversample counter is also cleared when both idles are high in RUN. This realigns tx_tick to frame start.

Optional Feature:
- Macro BAUD_SEQ_TIMEOUT_EN.
- Defined: a counter runs while in PENDING. When it reaches TIMEOUT-1 without both idles, the FSM goes to APPLY anyway and sets forced=1. forced clears on the next accepted request.
- Not defined: PENDING waits indefinitely, forced is tied to 0, and the TIMEOUT parameter is unused.

Decomposition:
- Shared package uart_pkg holds:
  - div codes: DIV_115200=2'b00, DIV_57600=2'b01, DIV_38400=2'b10, DIV_19200=2'b11;
  - the FSM state encoding (RUN, PENDING, APPLY, SETTLE, DONE);
  - the DEFAULT_OVERSAMPLE constant.
- One sub-module is natural: baud_tick_gen, covering the oversample counter, tick gating and the tx_tick wrap. The FSM stays in baud_sequencer.

Test Plan:
- Reset, then 25 scaled strobes with OVERSAMPLE=10 -> 25 rx_tick pulses, each 1 cycle after its strobe; tx_tick on strobes 10 and 20; div_out=00.
- req_div=11 with tx_idle=0 for 50 cycles -> PENDING for 50 cycles, ticks continue, req_ready=0. Raise both idles -> presc_clear pulses 1 cycle, then div_out=11, then change_done 1+SETTLE_CYCLES cycles later.
- req_div equal to the current div_out -> change_done 1 cycle after the handshake, no presc_clear.
- Scaled strobe in the APPLY cycle and one in SETTLE -> no rx_tick/tx_tick for either; the tx counter restarts at 0.
- Assert reset during SETTLE after a request for 10 -> div_out=00, state RUN, req_ready=1 on release.
- With BAUD_SEQ_TIMEOUT_EN and TIMEOUT=16, idles held low -> APPLY on cycle 16 of PENDING and forced=1; the next accepted request clears forced.
